// File: rtl/rv32_multicycle_core.sv
// Multicycle RV32I-subset core (OP-IMM, LUI, AUIPC, JAL) with req/valid fetch and error halt.
// Optional performance counters are enabled by defining CORE_PERF_CNT_EN.
module rv32_multicycle_core #(
  parameter int          ADDR_W   = 16,
  parameter int          NUM_REGS = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 20
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [31:0]       pc,
  output logic              retire,
  output logic              halted,
  output logic [1:0]        err_code,
  input  logic [4:0]        dbg_idx,
  output logic [31:0]       dbg_data
`ifdef CORE_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instret_cnt
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ALIGN   = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]        rs1_data_q, rs1_data_d;
  logic [31:0]        result_q, result_d;
  logic [31:0]        next_pc_q, next_pc_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [31:0]        regs_q [1:NUM_REGS-1];
  logic               reg_we;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, shamt;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_u, imm_j, jal_target;
  logic [31:0] rs1_val;
  logic        rd_ok, rs1_ok;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign shamt  = instr_q[24:20];
  assign funct7 = instr_q[31:25];
  assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_u  = {instr_q[31:12], 12'b0};
  assign imm_j  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
  assign jal_target = pc_q + imm_j;

  assign rd_ok  = ({1'b0, rd}  < 6'(NUM_REGS));
  assign rs1_ok = ({1'b0, rs1} < 6'(NUM_REGS));

  // Register reads go through a compare mux so x0 and out-of-range indices read as zero.
  always_comb begin
    rs1_val  = '0;
    dbg_data = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rs1 == 5'(i))     rs1_val  = regs_q[i];
      if (dbg_idx == 5'(i)) dbg_data = regs_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    wait_cnt_d = wait_cnt_q;
    rs1_data_d = rs1_data_q;
    result_d   = result_q;
    next_pc_d  = next_pc_q;
    err_code_d = err_code_q;
    reg_we     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT_FETCH;
      end

      S_WAIT_FETCH: begin
        if (mem_rvalid) begin
          instr_d = mem_rdata;
          state_d = S_DECODE;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = S_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      S_DECODE: begin
        rs1_data_d = rs1_val;
        state_d    = S_EXECUTE;
        unique case (opcode)
          OP_IMM: begin
            if (!rd_ok || !rs1_ok) state_d = S_ERROR;
            if (funct3 == 3'b001 && funct7 != 7'h00) state_d = S_ERROR;
            if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20) state_d = S_ERROR;
          end
          OP_LUI, OP_AUI, OP_JAL: begin
            if (!rd_ok) state_d = S_ERROR;
          end
          default: state_d = S_ERROR;
        endcase
        if (state_d == S_ERROR) err_code_d = ERR_ILLEGAL;
      end

      S_EXECUTE: begin
        next_pc_d = pc_q + 32'd4;
        result_d  = '0;
        state_d   = S_WRITEBACK;
        unique case (opcode)
          OP_IMM: begin
            unique case (funct3)
              3'b000: result_d = rs1_data_q + imm_i;
              3'b010: result_d = {31'b0, $signed(rs1_data_q) < $signed(imm_i)};
              3'b011: result_d = {31'b0, rs1_data_q < imm_i};
              3'b100: result_d = rs1_data_q ^ imm_i;
              3'b110: result_d = rs1_data_q | imm_i;
              3'b111: result_d = rs1_data_q & imm_i;
              3'b001: result_d = rs1_data_q << shamt;
              default: result_d = funct7[5] ? 32'($signed(rs1_data_q) >>> shamt)
                                            : rs1_data_q >> shamt;
            endcase
          end
          OP_LUI: result_d = imm_u;
          OP_AUI: result_d = pc_q + imm_u;
          default: begin
            // JAL: a misaligned target halts before anything architectural changes.
            result_d  = pc_q + 32'd4;
            next_pc_d = jal_target;
            if (jal_target[1:0] != 2'b00) begin
              err_code_d = ERR_ALIGN;
              state_d    = S_ERROR;
            end
          end
        endcase
      end

      S_WRITEBACK: begin
        reg_we  = (rd != 5'd0);
        pc_d    = next_pc_q;
        state_d = S_FETCH;
      end

      default: state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      wait_cnt_q <= '0;
      rs1_data_q <= '0;
      result_q   <= '0;
      next_pc_q  <= '0;
      err_code_q <= '0;
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      wait_cnt_q <= wait_cnt_d;
      rs1_data_q <= rs1_data_d;
      result_q   <= result_d;
      next_pc_q  <= next_pc_d;
      err_code_q <= err_code_d;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (reg_we && rd == 5'(i)) regs_q[i] <= result_q;
      end
    end
  end

  // The request is masked during reset so the bus sees no strobe while rst is low.
  assign mem_req  = rst && (state_q == S_FETCH);
  assign mem_addr = pc_q[ADDR_W-1:0];
  assign pc       = pc_q;
  assign retire   = (state_q == S_WRITEBACK);
  assign halted   = (state_q == S_ERROR);
  assign err_code = err_code_q;

`ifdef CORE_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (!halted) cycle_cnt_d = cycle_cnt_q + 32'd1;
    if (retire)  instret_cnt_d = instret_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: doc/rv32_multicycle_core.md
Name: rv32_multicycle_core

Overview:
- Parametrised successor to the fixed-wait FETCH/DECODE/EXECUTE/WRITEBACK processor sequencer.
- Multicycle RV32I-subset core that:
  - fetches 32-bit instructions over a req/valid memory handshake instead of fixed wait counts;
  - decodes OP-IMM, LUI, AUIPC and JAL;
  - owns a parametrised register file;
  - halts in an ERROR state with a cause code.
- Sits between the system RAM wrapper and the debug/VGA register display.

Parameters:
- ADDR_W, 16, width of mem_addr; the PC is 32 bits and its low ADDR_W bits drive mem_addr.
- NUM_REGS, 32, register count; legal values are 32 (RV32I) and 16 (RV32E). Any rd/rs1 index ≥ NUM_REGS is illegal.
- RESET_PC, 32'h0000_0000, PC value after reset.
- TIMEOUT, 20, maximum cycles spent in WAIT_FETCH before a bus-timeout error.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-low.
- mem_req, output, 1: one-cycle fetch request strobe.
- mem_addr, output, ADDR_W: fetch byte address, equal to pc[ADDR_W-1:0].
- mem_rdata, input, 32: instruction word.
- mem_rvalid, input, 1: mem_rdata valid; sampled only in WAIT_FETCH.
- pc, output, 32: current program counter.
- retire, output, 1: one-cycle pulse in WRITEBACK.
- halted, output, 1: high while in ERROR.
- err_code, output, 2: error cause. 0 = none, 1 = illegal instruction, 2 = fetch timeout, 3 = misaligned jump target.
- dbg_idx, input, 5: debug register select.
- dbg_data, output, 32: combinational read of x[dbg_idx]. Reads 0 for index 0 and for any index ≥ NUM_REGS.

Behaviour:
- Reset (rst low, asynchronous):
  - state = FETCH, pc = RESET_PC;
  - all registers = 0;
  - mem_req = 0, retire = 0, halted = 0, err_code = 0;
  - wait counter = 0, instruction latch = 0.
- x0 is hardwired to 0; writes to it are discarded.
- States and transitions:
  - FETCH: mem_req = 1 for exactly this cycle, mem_addr = pc, wait counter cleared. Always goes to WAIT_FETCH.
  - WAIT_FETCH:
    - If mem_rvalid = 1: latch mem_rdata, go to DECODE.
    - Else if counter == TIMEOUT-1: go to ERROR with err_code = 2.
    - Else: increment the counter.
    - A mem_rvalid asserted during the FETCH cycle itself is ignored.
  - DECODE:
    - Extract opcode, rd, rs1, funct3, funct7 and the I/U/J immediates; sign-extend I and J.
    - Register rs1_data.
    - Illegal cases go to ERROR with err_code = 1: unsupported opcode, unsupported funct3/funct7 combination, rd or rs1 ≥ NUM_REGS.
    - Otherwise go to EXECUTE.
  - EXECUTE: compute result and next_pc into registers.
    - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
    - Shift amount is imm[4:0]. SLLI/SRLI require funct7 = 0; SRAI requires funct7 = 0x20. Any other funct7 is illegal and is detected in DECODE.
    - LUI: result = {imm[31:12], 12'b0}.
    - AUIPC: result = pc + {imm, 12'b0}.
    - JAL: result = pc + 4, next_pc = pc + sext(J-imm).
      - If next_pc[1:0] ≠ 0: go to ERROR with err_code = 3, leaving rd and pc unchanged.
    - All other instructions: next_pc = pc + 4.
    - Arithmetic is modulo 2^32, with no overflow trap.
  - WRITEBACK: write rd (unless rd = 0), pc = next_pc, retire = 1. Go to FETCH.
  - ERROR: halted = 1, err_code is held, no writes occur. Only reset exits this state.
- Instruction latency:
  - With mem_rvalid arriving in the first WAIT_FETCH cycle, each instruction takes 5 cycles, and retire pulses every 5 cycles.
  - Each extra cycle of memory latency adds one cycle.
- Reset asserted mid-instruction aborts it; no partial register or pc update remains.

Optional Feature:
- Macro: CORE_PERF_CNT_EN.
- When defined:
  - Adds output ports cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0.
  - cycle_cnt increments every cycle while not halted.
  - instret_cnt increments on each retire.
  - Both counters wrap from 0xFFFF_FFFF to 0.
  - Both counters freeze in ERROR.
- When undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- ADDI x1,x0,5 (0x00500093) at pc 0, with rvalid one cycle after req:
  - retire asserts on the 5th cycle after reset release;
  - x1 = 5, pc = 4.
- LUI x2,0x12345 (0x12345137) then AUIPC x3,1 (0x00001197) at pc 8:
  - x2 = 0x12345000;
  - x3 = 0x00001008.
- ADDI x1,x0,-8 (0xFF800093) then SRAI x4,x1,1 (0x4010D213):
  - x4 = 0xFFFFFFFC.
  - ADDI x0,x0,1 (0x00100013) leaves dbg_data(idx 0) = 0.
- JAL x1,8 (0x008000EF) at pc 0x10:
  - x1 = 0x14, pc = 0x18.
  - A JAL with a target offset of 2 gives halted = 1, err_code = 3, pc unchanged.
- Fetch of word 0x00000000:
  - ERROR with err_code = 1;
  - retire never pulses;
  - rst low clears halted.
- mem_rvalid held 0:
  - after 20 WAIT_FETCH cycles, halted = 1 and err_code = 2;
  - with CORE_PERF_CNT_EN defined, cycle_cnt freezes.
